// File: rtl/sum_frame_accumulator.sv
// ============================================================================
// Module   : sum_frame_accumulator
// Purpose  : Sums FRAME_LEN adder results per frame and queues the frame
//            totals in a small FIFO. Optional saturation: SUM_FRAME_ACC_SAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sum_frame_accumulator #(
    parameter int DATA_W     = 9,
    parameter int ACC_W      = 12,
    parameter int FRAME_LEN  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             flush,
    output logic [ACC_W-1:0]                 out_data,
    output logic [$clog2(FRAME_LEN+1)-1:0]   out_len,
    output logic                             out_ovf,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int LEN_W = $clog2(FRAME_LEN + 1);
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [ACC_W-1:0]       r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic [ACC_W-1:0]       r_mem_data [FIFO_DEPTH];
    logic [LEN_W-1:0]       r_mem_len  [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W:0]         r_count;

    logic                   w_full;
    logic                   w_accept;
    logic                   w_flush;
    logic                   w_last;
    logic                   w_push;
    logic                   w_pop;
    logic [ACC_W-1:0]       w_addend;
    logic [ACC_W-1:0]       w_total;
    logic                   w_ovf_total;
    logic [LEN_W-1:0]       w_push_len;

    // ------------------------------------------------------------------
    // Control FSM: one dead cycle after reset, then flow-controlled run
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            ST_INIT: w_state_next = ST_RUN;
            ST_RUN:  in_ready     = !w_full;
            default: w_state_next = ST_INIT;
        endcase
    end

    assign w_full     = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_accept   = in_valid && in_ready;
    assign w_flush    = flush && in_ready;
    assign w_last     = w_accept && (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_push     = w_last || (w_flush && ((r_cnt != '0) || w_accept));
    assign w_pop      = out_valid && out_ready;
    assign w_addend   = w_accept ? ACC_W'(in_data) : '0;
    assign w_push_len = LEN_W'(r_cnt) + LEN_W'(w_accept);

`ifdef SUM_FRAME_ACC_SAT_EN
    logic                   r_ovf;
    logic [ACC_W:0]         w_sum_ext;
    logic                   r_mem_ovf [FIFO_DEPTH];

    // Inputs are unsigned, so a carry out means the true sum passed the max
    assign w_sum_ext   = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_total     = w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];
    assign w_ovf_total = r_ovf | w_sum_ext[ACC_W];
    assign out_ovf     = r_mem_ovf[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_ovf[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_ovf                <= 1'b0;
                r_mem_ovf[r_wr_ptr]  <= w_ovf_total;
            end else if (w_accept) begin
                r_ovf <= w_ovf_total;
            end
        end
    end
`else
    assign w_total     = r_acc + w_addend;
    assign w_ovf_total = 1'b0;
    assign out_ovf     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_push) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_total;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO; storage is cleared so the head reads zero after reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_len[i]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_total;
                r_mem_len[r_wr_ptr]  <= w_push_len;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem_data[r_rd_ptr];
    assign out_len   = r_mem_len[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_sum_frame_accumulator.sv
// ============================================================================
// Module   : tb_sum_frame_accumulator
// Purpose  : Self-checking bench for sum_frame_accumulator against a
//            queue-based frame model; directed scenarios plus random traffic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sum_frame_accumulator;

    localparam int DATA_W     = 9;
    localparam int ACC_W      = 10;
    localparam int FRAME_LEN  = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int LEN_W      = $clog2(FRAME_LEN + 1);
    localparam int ACC_MAX    = (1 << ACC_W) - 1;

    typedef struct packed {
        logic [ACC_W-1:0] d;
        logic [LEN_W-1:0] l;
        logic             o;
    } tot_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [DATA_W-1:0]  in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               flush = 1'b0;
    logic [ACC_W-1:0]   out_data;
    logic [LEN_W-1:0]   out_len;
    logic               out_ovf;
    logic               out_valid;
    logic               out_ready = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    tot_t  mq[$];
    int    pend[$];
    bit    m_known = 0;
    bit    m_run   = 0;
    bit    m_accepted;
    tot_t  last_pop;
    int    pop_cnt = 0;

    sum_frame_accumulator #(
        .DATA_W     (DATA_W),
        .ACC_W      (ACC_W),
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic tot_t make_total();
        tot_t t;
        int   s = 0;
        foreach (pend[i]) s += pend[i];
        t.l = LEN_W'(pend.size());
`ifdef SUM_FRAME_ACC_SAT_EN
        t.d = (s > ACC_MAX) ? ACC_W'(ACC_MAX) : ACC_W'(s);
        t.o = (s > ACC_MAX);
`else
        t.d = ACC_W'(s % (ACC_MAX + 1));
        t.o = 1'b0;
`endif
        return t;
    endfunction

    // One clock: check visible outputs against the model, then advance both
    task automatic tick();
        bit exp_ready, exp_valid, acc, fl, pop;
        exp_valid = (mq.size() > 0);
        exp_ready = m_run && (mq.size() < FIFO_DEPTH);
        if (m_known) begin
            n_cmp++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL in_ready @%0t: got %b want %b", $time, in_ready, exp_ready);
            end
            n_cmp++;
            if (out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, exp_valid);
            end
            if (exp_valid) begin
                n_cmp++;
                if ({out_data, out_len, out_ovf} !== mq[0]) begin
                    n_fail++;
                    $display("FAIL head @%0t: got d=%0d l=%0d o=%b want d=%0d l=%0d o=%b",
                             $time, out_data, out_len, out_ovf, mq[0].d, mq[0].l, mq[0].o);
                end
            end
        end
        m_accepted = 0;
        if (rst) begin
            mq.delete();
            pend.delete();
            m_run   = 0;
            m_known = 1;
        end else begin
            acc = in_valid && exp_ready;
            fl  = flush && exp_ready;
            pop = exp_valid && out_ready;
            if (pop) begin
                last_pop = mq.pop_front();
                pop_cnt++;
            end
            if (acc) pend.push_back(int'(in_data));
            if ((acc && pend.size() == FRAME_LEN) || (fl && pend.size() > 0)) begin
                mq.push_back(make_total());
                pend.delete();
            end
            m_accepted = acc;
            if (m_known) m_run = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed_beat(input int d);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        do begin
            tick();
            guard++;
        end while (!m_accepted && guard < 50);
        if (!m_accepted) begin
            n_cmp++;
            n_fail++;
            $display("FAIL feed_timeout: beat %0d never accepted", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        out_ready = 1'b1;
        while (mq.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        if (mq.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left", mq.size());
        end
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_pop(input string name, input int d, input int l, input bit o);
        n_cmp++;
        if (last_pop !== tot_t'({ACC_W'(d), LEN_W'(l), o})) begin
            n_fail++;
            $display("FAIL %s: got d=%0d l=%0d o=%b want d=%0d l=%0d o=%b",
                     name, last_pop.d, last_pop.l, last_pop.o, d, l, o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_len, out_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%0d l=%0d o=%b want all 0",
                     in_ready, out_valid, out_data, out_len, out_ovf);
        end
    endtask

    task automatic test_basic();
        int c0;
        out_ready = 1'b1;
        feed_beat(10); feed_beat(20); feed_beat(30); feed_beat(40);
        n_cmp++;
        if (!(out_valid === 1'b1 && out_data === ACC_W'(100) && out_len === LEN_W'(4))) begin
            n_fail++;
            $display("FAIL basic_total: got v=%b d=%0d l=%0d want v=1 d=100 l=4",
                     out_valid, out_data, out_len);
        end
        c0 = pop_cnt;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || pop_cnt != c0 + 1) begin
            n_fail++;
            $display("FAIL basic_one_cycle: got v=%b pops=%0d want v=0 pops=%0d",
                     out_valid, pop_cnt - c0, 1);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed_beat(1);
        in_valid = 1'b1;
        in_data  = 1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stall: got in_ready=%b want 0", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) feed_beat(1);
        drain();
        check_pop("full_third_total", 4, 4, 1'b0);
    endtask

    task automatic test_flush();
        int c0;
        out_ready = 1'b1;
        feed_beat(5); feed_beat(6);
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        check_pop("flush_alone", 11, 2, 1'b0);
        c0 = pop_cnt;
        flush = 1'b1; tick(); flush = 1'b0;
        tick(); tick();
        n_cmp++;
        if (pop_cnt != c0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: got pops=%0d v=%b want pops=0 v=0", pop_cnt - c0, out_valid);
        end
    endtask

    task automatic test_flush_with_beat();
        out_ready = 1'b1;
        feed_beat(5);
        flush = 1'b1; feed_beat(7); flush = 1'b0;
        tick();
        check_pop("flush_with_beat", 12, 2, 1'b0);
        for (int i = 0; i < 4; i++) feed_beat(1);
        tick();
        check_pop("after_flush_frame", 4, 4, 1'b0);
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) feed_beat(511);
        tick();
`ifdef SUM_FRAME_ACC_SAT_EN
        check_pop("ovf_frame", 1023, 4, 1'b1);
`else
        check_pop("ovf_frame", 1020, 4, 1'b0);
`endif
        for (int i = 0; i < 4; i++) feed_beat(1);
        tick();
        check_pop("ovf_next_frame", 4, 4, 1'b0);
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed_beat(3);
        feed_beat(9); feed_beat(9);
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready);
        end
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_run: got rdy=%b want 1", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) feed_beat(2);
        tick();
        check_pop("mid_reset_frame", 8, 4, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DATA_W'($urandom_range(0, 511));
            flush     = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_flush();
        test_flush_with_beat();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sum_frame_accumulator.md
Name: sum_frame_accumulator

Overview:
- Downstream stage of the adder. Consumes the adder's result stream over a valid/ready handshake.
- Sums FRAME_LEN consecutive results into one frame total.
- Queues finished totals in a small FIFO and presents them to the next consumer over a second valid/ready handshake.
- A flush request closes a partial frame early.

Parameters:
- DATA_W, 9, width of incoming sums (adder result width).
- ACC_W, 12, width of accumulator and frame total; ACC_W >= DATA_W.
- FRAME_LEN, 4, results per frame; >= 1.
- FIFO_DEPTH, 2, frame totals buffered; power of two, >= 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  result from adder (unsigned).
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a beat.
- flush  in  1  close current partial frame.
- out_data  out  ACC_W  frame total at FIFO head.
- out_len  out  clog2(FRAME_LEN+1)  beats summed into the head total.
- out_ovf  out  1  head total overflowed/saturated (0 when feature off).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream takes head.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_len=0, out_ovf=0. Accumulator, beat count, FIFO pointers and FIFO count cleared. FSM in INIT.
- FSM states:
  - INIT: in_ready=0 for exactly one cycle after reset deasserts, then go to RUN.
  - RUN: in_ready = !fifo_full. No other states.
- Input accept: on an edge where in_valid && in_ready.
  - Not last beat: acc <= acc + in_data; cnt <= cnt+1.
  - Last beat (cnt == FRAME_LEN-1): push {acc+in_data, FRAME_LEN, ovf} into the FIFO; acc <= 0; cnt <= 0.
- Arithmetic: in_data zero-extended to ACC_W; sum is modulo 2^ACC_W unless the optional feature is compiled in.
- Flush: sampled only when in_ready=1; ignored when the FIFO is full (caller holds it).
  - With cnt>0 or a beat accepted the same edge: push total of all pending beats including that beat; len = cnt (+1 if beat); clear acc and cnt.
  - With cnt=0 and no beat: no effect.
  - Flush on the natural last beat: single push only.
- Output:
  - out_valid = FIFO non-empty.
  - out_data, out_len and out_ovf reflect the FIFO head; stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
- Latency: a push at edge k gives out_valid=1 in cycle k+1 when the FIFO was empty.
- Simultaneous push and pop: both occur; occupancy unchanged. A push while full cannot occur because in_ready=0.
- Full: in_ready deasserts in the cycle after the push that fills the FIFO; it reasserts in the cycle after a pop.
- Reset mid-operation: partial frame discarded, FIFO emptied, out_valid=0 the cycle after rst, INIT re-entered.
- in_data is ignored when in_valid=0. No X propagates to outputs after reset.

Optional Feature:
- Macro: SUM_FRAME_ACC_SAT_EN.
- Defined:
  - Accumulation saturates at 2^ACC_W-1.
  - A sticky per-frame overflow bit is set on saturation and stored with the total as out_ovf.
  - Cleared at frame start.
- Undefined: wrap modulo 2^ACC_W; out_ovf tied to 0; no overflow logic.

Test Plan:
- Reset, then in_valid=1 with 10,20,30,40, out_ready=1 -> in_ready=0 for 1 cycle after reset. Single output out_data=100, out_len=4, out_valid high the cycle after the 4th accept, for one cycle.
- out_ready=0, stream twelve beats of 1 -> two entries of 4 queued. in_ready drops after the 8th accept. Setting out_ready=1 pops 4 and 4 and resumes input. Third total = 4.
- Accept 5 and 6, then flush alone -> out_data=11, out_len=2. A second flush with cnt=0 -> no push.
- Accept 5, then flush together with accepted beat 7 -> out_data=12, out_len=2. Next frame of 1,1,1,1 -> 4, len=4.
- With ACC_W=10, feed 511 x4:
  - Feature off -> out_data=1020, out_ovf=0.
  - SUM_FRAME_ACC_SAT_EN -> out_data=1023, out_ovf=1. Next frame 1 x4 -> 4, out_ovf=0.
- One total queued plus 2 beats pending, assert rst for 1 cycle -> out_valid=0, in_ready=0 then 1. A following frame 2,2,2,2 -> 8; the pending beats are not included.
